// File: rtl/rv_alu_encode.sv
// Encodes ALU R-type requests (ADD/SUB/AND/OR) into RV32I instruction words,
// buffered through a small FIFO; illegal op codes are dropped and counted.
module rv_alu_encode #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_alu_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        err,
    output logic [7:0]  err_count,
    output logic [15:0] enc_count
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3
    } alu_op_e;

    localparam logic [6:0] OPC_OP = 7'b0110011;

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_err;
    logic [7:0]    r_err_count;
    logic [15:0]   r_enc_count;

    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_legal;
    logic          w_push;
    logic          w_pop;
    logic [6:0]    w_funct7;
    logic [2:0]    w_funct3;
    logic [31:0]   w_word;

    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_legal  = (in_alu_op < 4'd4);
    assign w_accept = in_valid && !w_full;
    assign w_push   = w_accept && w_legal;
    assign w_pop    = !w_empty && out_ready;

    always_comb begin
        w_funct7 = 7'b0000000;
        w_funct3 = 3'b000;
        case (alu_op_e'(in_alu_op))
            OP_ADD: begin
                w_funct7 = 7'b0000000;
                w_funct3 = 3'b000;
            end
            OP_SUB: begin
                w_funct7 = 7'b0100000;
                w_funct3 = 3'b000;
            end
            OP_AND: begin
                w_funct7 = 7'b0000000;
                w_funct3 = 3'b111;
            end
            OP_OR: begin
                w_funct7 = 7'b0000000;
                w_funct3 = 3'b110;
            end
            default: begin
                w_funct7 = 7'b0000000;
                w_funct3 = 3'b000;
            end
        endcase
        w_word = {w_funct7, in_rs2, in_rs1, w_funct3, in_rd, OPC_OP};
    end

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_enc_count <= '0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_accept && !w_legal && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
            if (w_push) begin
                r_enc_count <= r_enc_count + 16'd1;
            end
        end
    end

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_instr = r_mem[r_rd_ptr];
    assign err       = r_err;
    assign err_count = r_err_count;
    assign enc_count = r_enc_count;

endmodule

// File: tb/tb_rv_alu_encode.sv
// Self-checking bench for rv_alu_encode: queue-based reference model compared
// every cycle, plus literal expectations from hand-encoded instruction words.
module tb_rv_alu_encode;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_alu_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        err;
    logic [7:0]  err_count;
    logic [15:0] enc_count;

    always #5 clk = ~clk;

    rv_alu_encode #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_alu_op (in_alu_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .err       (err),
        .err_count (err_count),
        .enc_count (enc_count)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic [31:0] q[$];
    logic        m_err;
    int unsigned m_errc;
    int unsigned m_enc;

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        int unsigned f7;
        int unsigned f3;
        f7 = 0;
        f3 = 0;
        case (op)
            4'd1: f7 = 32;
            4'd2: f3 = 7;
            4'd3: f3 = 6;
            default: ;
        endcase
        return 32'((f7 << 25) | (int'(rs2) << 20) | (int'(rs1) << 15)
                   | (f3 << 12) | (int'(rd) << 7) | 'h33);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("out_instr", out_instr, q[0]);
        chk("err", 32'(err), 32'(m_err));
        chk("err_count", 32'(err_count), m_errc);
        chk("enc_count", 32'(enc_count), m_enc & 32'hFFFF);
    endtask

    // One clock of the reference model, then compare at edge + 1.
    task automatic step();
        logic acc;
        logic pop;
        acc = in_valid && (q.size() < DEPTH);
        pop = (q.size() != 0) && out_ready;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        m_err = acc && (in_alu_op >= 4'd4);
        if (acc && in_alu_op < 4'd4) begin
            q.push_back(enc(in_alu_op, in_rd, in_rs1, in_rs2));
            m_enc++;
        end
        if (m_err && m_errc < 255) m_errc++;
        compare();
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
        in_valid  = 1'b1;
        in_alu_op = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        step();
    endtask

    task automatic model_reset();
        q.delete();
        m_err  = 1'b0;
        m_errc = 0;
        m_enc  = 0;
    endtask

    logic [31:0] w0;
    int unsigned enc_before;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_alu_op = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        out_ready = 1'b0;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare();
        chk("reset_instr", out_instr, 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Single ADD
        out_ready = 1'b1;
        send(4'd0, 5'd1, 5'd2, 5'd3);
        chk("add_word", out_instr, 32'h003100B3);
        chk("add_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        chk("add_enc", 32'(enc_count), 32'd1);
        chk("add_drain", 32'(out_valid), 32'd0);

        // Back-to-back SUB, AND, OR
        send(4'd1, 5'd5, 5'd6, 5'd7);
        chk("sub_word", out_instr, 32'h407302B3);
        send(4'd2, 5'd10, 5'd11, 5'd12);
        chk("and_word", out_instr, 32'h00C5F533);
        send(4'd3, 5'd31, 5'd31, 5'd31);
        chk("or_word", out_instr, 32'h01FFEFB3);
        in_valid = 1'b0;
        step();

        // Stall with a full FIFO, then release
        out_ready = 1'b0;
        send(4'd0, 5'd4, 5'd0, 5'd0);
        w0 = enc(4'd0, 5'd4, 5'd0, 5'd0);
        send(4'd0, 5'd8, 5'd0, 5'd0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        send(4'd0, 5'd9, 5'd0, 5'd0);
        chk("stall_stable", out_instr, w0);
        step();
        chk("stall_stable2", out_instr, w0);
        out_ready = 1'b1;
        step();
        chk("pop_frees_slot", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Illegal ops interleaved with legal ones
        enc_before = m_enc;
        send(4'd0, 5'd1, 5'd1, 5'd1);
        send(4'd4, 5'd2, 5'd2, 5'd2);
        chk("err_pulse_op4", 32'(err), 32'd1);
        send(4'd3, 5'd3, 5'd3, 5'd3);
        chk("err_clear", 32'(err), 32'd0);
        send(4'hF, 5'd4, 5'd4, 5'd4);
        chk("err_pulse_opF", 32'(err), 32'd1);
        send(4'd1, 5'd5, 5'd5, 5'd5);
        in_valid = 1'b0;
        step();
        step();
        chk("err_count_2", 32'(err_count), 32'd2);
        chk("enc_legal_only", 32'(enc_count), 32'(enc_before + 3));

        // Saturation of the error counter
        for (int i = 0; i < 300; i++) send(4'(4 + (i % 12)), 5'(i), 5'(i + 1), 5'(i + 2));
        chk("err_held_high", 32'(err), 32'd1);
        in_valid = 1'b0;
        step();
        chk("err_sat", 32'(err_count), 32'd255);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_alu_op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15))
                                                    : 4'($urandom_range(0, 3));
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        // Asynchronous reset with two words buffered
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        send(4'd0, 5'd1, 5'd2, 5'd3);
        send(4'd1, 5'd1, 5'd2, 5'd3);
        in_valid = 1'b0;
        chk("pre_reset_full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare();
        chk("post_reset_enc", 32'(enc_count), 32'd0);
        chk("post_reset_errc", 32'(err_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
